// File: rtl/biquad_filter_seq_if.sv
// Sample/coefficient handshake bundle for the biquad section.
// The master drives samples and coefficients; the slave is the filter.
interface biquad_filter_seq_if #(
  parameter int N = 12,
  parameter int C = 16
);
  logic signed [N-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic                coef_we;
  logic [2:0]          coef_sel;
  logic signed [C-1:0] coef_data;
  logic                bypass;
  logic signed [N-1:0] out_data;
  logic                out_valid;
  logic                sat_flag;

  modport master (
    output in_data, in_valid, coef_we, coef_sel, coef_data, bypass,
    input  in_ready, out_data, out_valid, sat_flag
  );

  modport slave (
    input  in_data, in_valid, coef_we, coef_sel, coef_data, bypass,
    output in_ready, out_data, out_valid, sat_flag
  );
endinterface

// File: rtl/biquad_filter_seq.sv
// Direct-form-I biquad with one shared multiplier: 1 accept, 5 MAC, 1 writeback cycle.
// Output is rounded half-up and saturated; bypass passes x through with the same timing.
module biquad_filter_seq #(
  parameter int N = 12,
  parameter int C = 16,
  parameter int F = 14,
  parameter int G = 4
) (
  input logic               clk,
  input logic               rst,
  biquad_filter_seq_if.slave bus
);
  localparam int A = N + C + G;
  localparam logic signed [A-1:0] RND   = {{(A-F){1'b0}}, 1'b1, {(F-1){1'b0}}};
  localparam logic signed [A-1:0] Y_MAX = {{(A-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [A-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {IDLE, MAC, WB} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          idx_reg;
  logic signed [N-1:0] x_reg, x1_reg, x2_reg, y1_reg, y2_reg;
  logic                bypass_reg;
  logic signed [A-1:0] acc_reg;
  logic signed [N-1:0] out_data_reg;
  logic                out_valid_reg;
  logic                sat_flag_reg;

  logic                ready;
  logic                accept;
  logic signed [C-1:0] coef_act [5];

  logic signed [N-1:0]   op_x;
  logic signed [C-1:0]   op_c;
  logic                  op_sub;
  logic signed [N+C-1:0] prod;
  logic signed [A-1:0]   prod_ext;
  logic signed [A-1:0]   rnd_sum;
  logic signed [A-1:0]   r;
  logic                  sat_hi, sat_lo;
  logic signed [N-1:0]   y_sat, y_val;

  // Shadow bank is written any time; active bank snapshots it only on accept,
  // so the sample in flight always uses one consistent coefficient set.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_coef
      localparam logic signed [C-1:0] RESET_VAL = (gi == 0) ? C'(1 << F) : '0;
      logic signed [C-1:0] shadow_reg;
      logic signed [C-1:0] active_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg <= RESET_VAL;
          active_reg <= RESET_VAL;
        end else begin
          if (bus.coef_we && bus.coef_sel == 3'(gi)) shadow_reg <= bus.coef_data;
          if (accept) active_reg <= shadow_reg;
        end
      end

      assign coef_act[gi] = active_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        ready  = !rst;
        accept = bus.in_valid && !rst;
        if (accept) state_next = MAC;
      end
      MAC: begin
        if (idx_reg == 3'd4) state_next = WB;
      end
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    op_x   = x_reg;
    op_c   = coef_act[0];
    op_sub = 1'b0;
    case (idx_reg)
      3'd1: begin op_x = x1_reg; op_c = coef_act[1]; end
      3'd2: begin op_x = x2_reg; op_c = coef_act[2]; end
      3'd3: begin op_x = y1_reg; op_c = coef_act[3]; op_sub = 1'b1; end
      3'd4: begin op_x = y2_reg; op_c = coef_act[4]; op_sub = 1'b1; end
      default: ;
    endcase
  end

  assign prod     = op_x * op_c;
  assign prod_ext = {{G{prod[N+C-1]}}, prod};

  // Round half toward +inf, then clamp to the N-bit range.
  assign rnd_sum = acc_reg + RND;
  assign r       = rnd_sum >>> F;
  assign sat_hi  = r > Y_MAX;
  assign sat_lo  = r < Y_MIN;
  assign y_sat   = sat_hi ? Y_MAX[N-1:0] : (sat_lo ? Y_MIN[N-1:0] : r[N-1:0]);
  assign y_val   = bypass_reg ? x_reg : y_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg       <= '0;
      x_reg         <= '0;
      x1_reg        <= '0;
      x2_reg        <= '0;
      y1_reg        <= '0;
      y2_reg        <= '0;
      bypass_reg    <= 1'b0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      sat_flag_reg  <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      if (accept) begin
        x_reg      <= bus.in_data;
        bypass_reg <= bus.bypass;
        acc_reg    <= '0;
        idx_reg    <= '0;
      end
      if (state_reg == MAC) begin
        acc_reg <= op_sub ? (acc_reg - prod_ext) : (acc_reg + prod_ext);
        idx_reg <= idx_reg + 3'd1;
      end
      if (state_reg == WB) begin
        out_data_reg  <= y_val;
        out_valid_reg <= 1'b1;
        x2_reg        <= x1_reg;
        x1_reg        <= x_reg;
        y2_reg        <= y1_reg;
        y1_reg        <= y_val;
        if (!bypass_reg && (sat_hi || sat_lo)) sat_flag_reg <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sat_flag  = sat_flag_reg;
endmodule

// File: tb/tb_biquad_filter_seq.sv
// Table-driven bench for biquad_filter_seq with an output scoreboard that also
// checks the accept-to-out_valid latency of every sample.
module tb_biquad_filter_seq;
  localparam int N = 12;
  localparam int C = 16;
  localparam int F = 14;
  localparam int G = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  biquad_filter_seq_if #(.N(N), .C(C)) bus ();

  biquad_filter_seq #(.N(N), .C(C), .F(F), .G(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int y;
    int cyc;
  } exp_t;

  typedef struct {
    bit               load;
    int               b0, b1, b2, a1, a2;
    bit               bp;
    bit               sat;
    int               len;
    logic [11:0][11:0] xs;
    logic [11:0][11:0] ys;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   ov_count = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: every out_valid pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        ov_count++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out_valid: got out_data %0d, expected no output",
                   int'(bus.out_data));
        end else begin
          e = sb.pop_front();
          $display("out: y=%0d expected=%0d latency=%0d", int'(bus.out_data), e.y, cyc - e.cyc);
          check("out_data", int'(bus.out_data), e.y);
          check("latency", cyc - e.cyc, 6);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input bit load, input int b0, input int b1, input int b2,
                              input int a1, input int a2, input bit bp, input bit sat);
    vec_t v;
    v.load = load; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.a1 = a1; v.a2 = a2;
    v.bp = bp; v.sat = sat; v.len = 0; v.xs = '0; v.ys = '0;
    return v;
  endfunction

  task automatic add(inout vec_t v, input int x, input int y);
    v.xs[v.len] = 12'(x);
    v.ys[v.len] = 12'(y);
    v.len++;
  endtask

  // All driving tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_sat_flag", int'(bus.sat_flag), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic coef_write(input int sel, input int val);
    bus.coef_we   = 1'b1;
    bus.coef_sel  = 3'(sel);
    bus.coef_data = 16'(val);
    @(posedge clk);
    #1 bus.coef_we = 1'b0;
  endtask

  task automatic send(input int x, input int y, input bit hold, input bit bp, output int waits);
    exp_t e;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 12'(x);
    bus.bypass   = bp;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 50) break;
    end
    if (waits > 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, expected accept", waits);
    end else begin
      e.y = y;
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending outputs, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    int   w;
    int   ov_before;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.bypass = 1'b0;
    bus.coef_we = 1'b0; bus.coef_sel = '0; bus.coef_data = '0;

    v = mk(0, 0, 0, 0, 0, 0, 0, 0);
    add(v, 100, 100); add(v, 0, 0); add(v, 0, 0);
    vecs[0] = v;
    v = mk(1, 8192, 8192, 0, 0, 0, 0, 0);
    add(v, 100, 50); add(v, 200, 150); add(v, 0, 100);
    vecs[1] = v;
    v = mk(1, 16384, 0, 0, -8192, 0, 0, 0);
    add(v, 1000, 1000); add(v, 0, 500); add(v, 0, 250); add(v, 0, 125);
    add(v, 0, 63); add(v, 0, 32); add(v, 0, 16); add(v, 0, 8);
    add(v, 0, 4); add(v, 0, 2); add(v, 0, 1); add(v, 0, 1);
    vecs[2] = v;
    v = mk(1, 32767, 0, 0, 0, 0, 0, 1);
    add(v, 2047, 2047); add(v, -2048, -2048); add(v, 0, 0);
    vecs[3] = v;
    v = mk(1, 32767, 0, 0, 0, 0, 1, 0);
    add(v, 2047, 2047); add(v, -7, -7);
    vecs[4] = v;
    v = mk(1, 0, 0, 16384, 0, 0, 0, 0);
    add(v, 10, 0); add(v, 20, 0); add(v, 30, 10); add(v, 40, 20);
    vecs[5] = v;
    v = mk(1, 16384, 0, 0, 0, -16384, 0, 0);
    add(v, 5, 5); add(v, 0, 0); add(v, 0, 5); add(v, 0, 0); add(v, 0, 5);
    vecs[6] = v;

    #1;
    for (int i = 0; i < 7; i++) begin
      do_reset();
      if (vecs[i].load) begin
        coef_write(0, vecs[i].b0);
        coef_write(1, vecs[i].b1);
        coef_write(2, vecs[i].b2);
        coef_write(3, vecs[i].a1);
        coef_write(4, vecs[i].a2);
      end
      for (int k = 0; k < vecs[i].len; k++)
        send(int'($signed(vecs[i].xs[k])), int'($signed(vecs[i].ys[k])), 1'b0, vecs[i].bp, w);
      drain();
      check($sformatf("sat_flag_vec%0d", i), int'(bus.sat_flag), int'(vecs[i].sat));
    end

    // Streaming with in_valid held high; b0 rewritten while sample 2 is in MAC.
    do_reset();
    send(1, 1, 1'b1, 1'b0, w);
    send(2, 2, 1'b1, 1'b0, w);
    check("stream_gap_s2", w, 6);
    coef_write(0, 0);
    send(3, 0, 1'b1, 1'b0, w);
    send(4, 0, 1'b1, 1'b0, w);
    check("stream_gap_s4", w, 6);
    send(5, 0, 1'b1, 1'b0, w);
    check("stream_gap_s5", w, 6);
    bus.in_valid = 1'b0;
    drain();

    // Reset in the middle of a sample: abort, then defaults must be restored.
    do_reset();
    coef_write(0, 8192);
    coef_write(3, -8192);
    send(40, 20, 1'b0, 1'b0, w);
    drain();
    bus.in_valid = 1'b1;
    bus.in_data  = 12'sd55;
    w = 0;
    while (w < 50) begin
      @(negedge clk);
      if (bus.in_ready) break;
      w++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ov_before = ov_count;
    @(negedge clk);
    check("in_ready_after_abort", int'(bus.in_ready), 1);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_out_valid", ov_count, ov_before);
    send(100, 100, 1'b0, 1'b0, w);
    drain();
    check("sat_flag_after_abort", int'(bus.sat_flag), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
